// File: rtl/fmap_pingpong_buf_if.sv
// Producer/consumer bundle for the ping-pong feature-map buffer.
// The buffer takes the slave side; the surrounding layers (or a bench) take master.
interface fmap_pingpong_buf_if #(
   parameter int DATA_WIDTH = 32
);
   logic                  wr_valid;
   logic [DATA_WIDTH-1:0] wr_data;
   logic                  wr_ready;
   logic                  wr_frame_done;
   logic                  rd_start;
   logic                  rd_en;
   logic [DATA_WIDTH-1:0] rd_data;
   logic                  rd_valid;
   logic                  rd_frame_done;
   logic                  rd_busy;
   logic [1:0]            full_cnt;
   logic                  wr_bank;
   logic                  rd_bank;

   modport master (
      output wr_valid, wr_data, rd_start, rd_en,
      input  wr_ready, wr_frame_done, rd_data, rd_valid, rd_frame_done,
             rd_busy, full_cnt, wr_bank, rd_bank
   );

   modport slave (
      input  wr_valid, wr_data, rd_start, rd_en,
      output wr_ready, wr_frame_done, rd_data, rd_valid, rd_frame_done,
             rd_busy, full_cnt, wr_bank, rd_bank
   );
endinterface

// File: rtl/fmap_pingpong_buf.sv
// Double-banked feature-map buffer: the producer fills one bank while the consumer
// drains the other, with write back-pressure, queued read starts and output rescaling.
module fmap_pingpong_buf #(
   parameter int DATA_WIDTH = 32,
   parameter int CH         = 8,
   parameter int MAP_SIZE   = 13,
   parameter int OUT_SHIFT  = 0
) (
   input logic                clk,
   input logic                rst_n,
   fmap_pingpong_buf_if.slave bus
);
   localparam int DEPTH      = CH * MAP_SIZE * MAP_SIZE;
   localparam int ADDR_WIDTH = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

   typedef enum logic [1:0] {R_IDLE, R_WAIT, R_READ} rd_state_t;

   rd_state_t state, state_next;

   logic [DATA_WIDTH-1:0]        mem [2][DEPTH];
   logic [1:0]                   full, full_next;
   logic [1:0]                   full_cnt;
   logic [ADDR_WIDTH-1:0]        wr_addr, rd_addr;
   logic                         wr_bank, rd_bank;
   logic                         wr_accept, wr_last;
   logic                         rd_go, rd_last, rd_busy;
   logic                         wr_frame_done;
   logic signed [DATA_WIDTH-1:0] rd_word;
   logic [DATA_WIDTH-1:0]        rd_data;
   logic                         rd_valid, rd_frame_done;

   assign wr_accept = bus.wr_valid & ~full[wr_bank];
   assign wr_last   = wr_accept & (wr_addr == LAST_ADDR);
   assign rd_last   = rd_go & (rd_addr == LAST_ADDR);
   assign rd_word   = mem[rd_bank][rd_addr];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= R_IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      case (state)
         R_IDLE: if (bus.rd_start) state_next = full[rd_bank] ? R_READ : R_WAIT;
         R_WAIT: if (full[rd_bank]) state_next = R_READ;
         R_READ: if (rd_last) state_next = R_IDLE;
         default: state_next = R_IDLE;
      endcase
   end

   always_comb begin
      rd_go   = (state == R_READ) & bus.rd_en;
      rd_busy = (state != R_IDLE);
   end

   // Banks being read are always full, so the write and read completions can never
   // touch the same flag in one cycle.
   always_comb begin
      full_next = full;
      if (wr_last) full_next[wr_bank] = 1'b1;
      if (rd_last) full_next[rd_bank] = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (wr_accept) mem[wr_bank][wr_addr] <= bus.wr_data;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_addr       <= '0;
         wr_bank       <= 1'b0;
         full          <= 2'b00;
         full_cnt      <= 2'd0;
         wr_frame_done <= 1'b0;
      end else begin
         full          <= full_next;
         full_cnt      <= {1'b0, full_next[0]} + {1'b0, full_next[1]};
         wr_frame_done <= wr_last;
         if (wr_last) begin
            wr_addr <= '0;
            wr_bank <= ~wr_bank;
         end else if (wr_accept) begin
            wr_addr <= wr_addr + ADDR_WIDTH'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_addr       <= '0;
         rd_bank       <= 1'b0;
         rd_data       <= '0;
         rd_valid      <= 1'b0;
         rd_frame_done <= 1'b0;
      end else begin
         rd_valid      <= rd_go;
         rd_frame_done <= rd_last;
         if (rd_go) rd_data <= DATA_WIDTH'(rd_word >>> OUT_SHIFT);
         if (state != R_READ || rd_last) begin
            rd_addr <= '0;
         end else if (rd_go) begin
            rd_addr <= rd_addr + ADDR_WIDTH'(1);
         end
         if (rd_last) rd_bank <= ~rd_bank;
      end
   end

   assign bus.wr_ready      = ~full[wr_bank];
   assign bus.wr_frame_done = wr_frame_done;
   assign bus.rd_data       = rd_data;
   assign bus.rd_valid      = rd_valid;
   assign bus.rd_frame_done = rd_frame_done;
   assign bus.rd_busy       = rd_busy;
   assign bus.full_cnt      = full_cnt;
   assign bus.wr_bank       = wr_bank;
   assign bus.rd_bank       = rd_bank;
endmodule

// File: tb/tb_fmap_pingpong_buf.sv
// Scoreboard bench for fmap_pingpong_buf: a frame-queue model predicts every cycle's
// status and each read word; monitors compare whenever the DUTs present outputs.
module tb_fmap_pingpong_buf;
   localparam int DW    = 32;
   localparam int CH    = 2;
   localparam int MS    = 3;
   localparam int DEPTH = CH * MS * MS;

   typedef struct {
      logic       wr_ready;
      logic [1:0] full_cnt;
      logic       wr_frame_done;
      logic       rd_valid;
      logic       rd_frame_done;
      logic       rd_busy;
      logic       wr_bank;
      logic       rd_bank;
   } status_t;

   typedef struct {
      logic [31:0] data;
      logic        last;
   } rd_item_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   fmap_pingpong_buf_if #(.DATA_WIDTH(DW)) bus ();
   fmap_pingpong_buf_if #(.DATA_WIDTH(DW)) sh_bus ();

   fmap_pingpong_buf #(.DATA_WIDTH(DW), .CH(CH), .MAP_SIZE(MS), .OUT_SHIFT(0)) dut (
      .clk(clk), .rst_n(rst_n), .bus(bus)
   );
   fmap_pingpong_buf #(.DATA_WIDTH(DW), .CH(CH), .MAP_SIZE(MS), .OUT_SHIFT(6)) dut_sh (
      .clk(clk), .rst_n(rst_n), .bus(sh_bus)
   );

   int tests = 0;
   int fails = 0;

   status_t     status_q[$];
   rd_item_t    rd_q[$];
   logic [31:0] sh_q[$];

   // Model: complete frames wait in 'stored' in arrival order; a frame stays counted
   // as full until its final word has been read.
   int          mfull, rd_idx, wframes, rframes;
   bit          waiting, reading;
   logic [31:0] partial[$];
   logic [31:0] stored[$];

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("[TB] FAIL %s: got %0d, expected %0d", name, $signed(act), $signed(exp));
      end
   endtask

   task automatic modelReset();
      mfull = 0; rd_idx = 0; wframes = 0; rframes = 0;
      waiting = 0; reading = 0;
      partial.delete(); stored.delete();
      rd_q.delete(); status_q.delete();
   endtask

   task automatic modelStep(input bit wv, input logic [31:0] wd, input bit rs, input bit re);
      int          full_pre;
      bit          wdone, rdone, rv, last;
      logic [31:0] w;
      status_t     s;
      full_pre = mfull;
      wdone = 0; rdone = 0; rv = 0; last = 0;
      if (reading) begin
         if (re) begin
            w = stored.pop_front();
            rv = 1;
            last = (rd_idx == DEPTH - 1);
            rd_q.push_back('{data: w, last: last});
            rd_idx++;
            if (last) begin
               rd_idx = 0; rdone = 1; reading = 0;
            end
         end
      end else if (waiting) begin
         if (full_pre > 0) begin
            waiting = 0; reading = 1;
         end
      end else if (rs) begin
         if (full_pre > 0) reading = 1;
         else waiting = 1;
      end
      if (wv && full_pre < 2) begin
         partial.push_back(wd);
         if (partial.size() == DEPTH) begin
            foreach (partial[i]) stored.push_back(partial[i]);
            partial.delete();
            wdone = 1;
         end
      end
      mfull = full_pre + int'(wdone) - int'(rdone);
      wframes += int'(wdone);
      rframes += int'(rdone);
      s.wr_ready      = (mfull < 2);
      s.full_cnt      = 2'(mfull);
      s.wr_frame_done = wdone;
      s.rd_valid      = rv;
      s.rd_frame_done = rv && last;
      s.rd_busy       = reading || waiting;
      s.wr_bank       = wframes[0];
      s.rd_bank       = rframes[0];
      status_q.push_back(s);
   endtask

   task automatic applyStimulus(input bit wv, input logic [31:0] wd, input bit rs, input bit re);
      @(posedge clk);
      #2;
      bus.wr_valid = wv;
      bus.wr_data  = wd;
      bus.rd_start = rs;
      bus.rd_en    = re;
      modelStep(wv, wd, rs, re);
   endtask

   task automatic resetDut();
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      bus.wr_valid = 0; bus.wr_data = '0; bus.rd_start = 0; bus.rd_en = 0;
      sh_bus.wr_valid = 0; sh_bus.wr_data = '0; sh_bus.rd_start = 0; sh_bus.rd_en = 0;
      modelReset();
      #1;
      checkOutput("reset_wr_ready", bus.wr_ready, 1);
      checkOutput("reset_full_cnt", bus.full_cnt, 0);
      checkOutput("reset_rd_valid", bus.rd_valid, 0);
      checkOutput("reset_rd_busy", bus.rd_busy, 0);
      checkOutput("reset_wr_frame_done", bus.wr_frame_done, 0);
      checkOutput("reset_rd_frame_done", bus.rd_frame_done, 0);
      checkOutput("reset_wr_bank", bus.wr_bank, 0);
      checkOutput("reset_rd_bank", bus.rd_bank, 0);
      repeat (2) @(posedge clk);
      #2;
      rst_n = 1'b1;
      modelStep(0, '0, 0, 0);
   endtask

   task automatic writeFrame(input int base);
      for (int i = 0; i < DEPTH; i++) applyStimulus(1, 32'(base + i), 0, 0);
   endtask

   task automatic readFrame();
      applyStimulus(0, '0, 1, 0);
      for (int i = 0; i < DEPTH; i++) applyStimulus(0, '0, 0, 1);
   endtask

   // Main monitor: per-cycle status from the model plus in-order read data.
   initial begin
      status_t  s;
      rd_item_t r;
      forever begin
         @(posedge clk);
         #1;
         if (status_q.size() > 0) begin
            s = status_q.pop_front();
            checkOutput("wr_ready", bus.wr_ready, s.wr_ready);
            checkOutput("full_cnt", bus.full_cnt, s.full_cnt);
            checkOutput("wr_frame_done", bus.wr_frame_done, s.wr_frame_done);
            checkOutput("rd_valid", bus.rd_valid, s.rd_valid);
            checkOutput("rd_busy", bus.rd_busy, s.rd_busy);
            checkOutput("wr_bank", bus.wr_bank, s.wr_bank);
            checkOutput("rd_bank", bus.rd_bank, s.rd_bank);
         end
         if (bus.rd_valid === 1'b1) begin
            if (rd_q.size() == 0) begin
               checkOutput("rd_valid_unexpected", bus.rd_valid, 0);
            end else begin
               r = rd_q.pop_front();
               checkOutput("rd_data", bus.rd_data, r.data);
               checkOutput("rd_frame_done", bus.rd_frame_done, r.last);
            end
         end
      end
   end

   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (sh_bus.rd_valid === 1'b1) begin
            if (sh_q.size() == 0) checkOutput("sh_rd_valid_unexpected", sh_bus.rd_valid, 0);
            else checkOutput("sh_rd_data", sh_bus.rd_data, sh_q.pop_front());
         end
      end
   end

   initial begin
      logic signed [31:0] sw [DEPTH];
      bus.wr_valid = 0; bus.wr_data = '0; bus.rd_start = 0; bus.rd_en = 0;
      sh_bus.wr_valid = 0; sh_bus.wr_data = '0; sh_bus.rd_start = 0; sh_bus.rd_en = 0;
      resetDut();

      writeFrame(0);
      applyStimulus(0, '0, 0, 0);
      readFrame();
      applyStimulus(0, '0, 0, 0);

      writeFrame(0);
      writeFrame(18);
      applyStimulus(1, 32'd999, 0, 0);
      readFrame();
      readFrame();
      applyStimulus(0, '0, 0, 0);

      resetDut();
      applyStimulus(0, '0, 1, 0);
      for (int i = 0; i < DEPTH; i++) applyStimulus(1, 32'(200 + i), 0, i[0]);
      for (int i = 0; i < DEPTH + 2; i++) applyStimulus(0, '0, 0, 1);

      // Alternate-cycle reads of one bank while the other fills; both frames finish together.
      writeFrame(300);
      applyStimulus(0, '0, 1, 0);
      for (int i = 0; i < 2 * DEPTH; i++)
         applyStimulus(i >= DEPTH, 32'(100 + i - DEPTH), 0, i[0]);
      readFrame();

      writeFrame(400);
      for (int i = 0; i < 7; i++) applyStimulus(1, 32'(500 + i), 0, 0);
      resetDut();
      writeFrame(50);
      applyStimulus(0, '0, 0, 0);
      readFrame();

      for (int i = 0; i < 1500; i++)
         applyStimulus($urandom_range(0, 99) < 70, $urandom, $urandom_range(0, 99) < 6,
                       $urandom_range(0, 99) < 60);
      repeat (3) applyStimulus(0, '0, 0, 0);

      sw[0] = -128; sw[1] = 640; sw[2] = 63;
      for (int i = 3; i < DEPTH; i++) sw[i] = $signed($urandom);
      for (int i = 0; i < DEPTH; i++) begin
         @(posedge clk); #2;
         sh_bus.wr_valid = 1; sh_bus.wr_data = sw[i];
      end
      @(posedge clk); #2;
      sh_bus.wr_valid = 0; sh_bus.rd_start = 1;
      for (int i = 0; i < DEPTH; i++) begin
         @(posedge clk); #2;
         sh_bus.rd_start = 0; sh_bus.rd_en = 1;
         sh_q.push_back(32'(sw[i] >>> 6));
      end
      @(posedge clk); #2;
      sh_bus.rd_en = 0;

      repeat (3) @(posedge clk);
      #3;
      checkOutput("rd_queue_drained", rd_q.size(), 0);
      checkOutput("status_queue_drained", status_q.size(), 0);
      checkOutput("sh_queue_drained", sh_q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
